// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational 4-bit ALU
// between two requesters. Each operation is accepted in IDLE. Its result is
// captured in EXEC and handed off on a tagged response channel in RESP.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_in1,
  input  logic [7:0]       req_in2,
  input  logic [3:0]       req_opcode,
  output logic [3:0]       alu_in1,
  output logic [3:0]       alu_in2,
  output logic [1:0]       alu_opcode,
  input  logic [7:0]       alu_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [7:0]       resp_data,
  output logic             resp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             grant_s;
  logic             accept_s;
  logic             handoff_s;
  logic             div_zero_s;
  logic [3:0]       in1_q, in2_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic             resp_id_q;
  logic [7:0]       resp_data_q;
  logic             resp_err_q;
  logic [CNT_W-1:0] op_count_q;

  // The only operation the ALU cannot answer meaningfully: divide by zero.
  function automatic logic is_div_zero(input logic [1:0] op, input logic [3:0] divisor);
    return (op == 2'b11) && (divisor == 4'd0);
  endfunction

  assign div_zero_s = is_div_zero(op_q, in2_q);

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req_valid == 2'b11) begin
      grant_s = ~last_grant_q;
    end else if (req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end

  // Next-state logic plus the accept/handoff strobes and the ready bits.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept_s  = 1'b0;
    handoff_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant_s ? 2'b10 : 2'b01;
          accept_s  = 1'b1;
          state_d   = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          handoff_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers feeding the ALU; they change only when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      in1_q <= 4'd0;
      in2_q <= 4'd0;
      op_q  <= 2'b00;
      id_q  <= 1'b0;
    end else if (accept_s) begin
      in1_q <= grant_s ? req_in1[7:4]    : req_in1[3:0];
      in2_q <= grant_s ? req_in2[7:4]    : req_in2[3:0];
      op_q  <= grant_s ? req_opcode[3:2] : req_opcode[1:0];
      id_q  <= grant_s;
    end
  end

  // Capture the ALU result in EXEC; a divide by zero reports error with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id_q   <= 1'b0;
      resp_data_q <= 8'h00;
      resp_err_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_id_q   <= id_q;
      resp_err_q  <= div_zero_s;
      resp_data_q <= div_zero_s ? 8'h00 : alu_out;
    end
  end

  // Completed-operation counter and round-robin history, both advanced on handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q   <= {CNT_W{1'b0}};
      last_grant_q <= 1'b1;
    end else if (handoff_s) begin
      op_count_q   <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      last_grant_q <= resp_id_q;
    end
  end

  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_opcode = op_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter, with a
// behavioural 4-bit ALU attached to the alu_* ports. The DUT is built with
// CNT_W=4 so that the counter wrap is reachable in a short run.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_in1, req_in2;
  logic [3:0] req_opcode;
  logic [3:0] alu_in1, alu_in2;
  logic [1:0] alu_opcode;
  logic [7:0] alu_out;
  logic       resp_valid, resp_ready, resp_id, resp_err;
  logic [7:0] resp_data;
  logic [3:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  alu_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_opcode(req_opcode),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU: add/sub wrap in 4 bits, divide by zero returns all ones.
  always_comb begin
    alu_out = 8'h00;
    case (alu_opcode)
      2'b00: alu_out = {4'h0, alu_in1 + alu_in2};
      2'b01: alu_out = {4'h0, alu_in1 - alu_in2};
      2'b10: alu_out = {4'h0, alu_in1} * {4'h0, alu_in2};
      2'b11: alu_out = (alu_in2 == 4'd0) ? 8'hFF : {4'h0, alu_in1 / alu_in2};
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (id == 1) begin
      req_in1[7:4] = a; req_in2[7:4] = b; req_opcode[3:2] = op;
    end else begin
      req_in1[3:0] = a; req_in2[3:0] = b; req_opcode[1:0] = op;
    end
    req_valid[id] = 1'b1;
  endtask

  // Called at a negedge in IDLE: check the grant, let the accept edge pass, withdraw the winner.
  task automatic grant_step(input string tag, input int id);
    #1;
    check(tag, 16'(req_ready), (id == 1) ? 16'h0002 : 16'h0001);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  // Called at the negedge in EXEC: check the response, hand it off, check the counter.
  task automatic expect_resp(input string tag, input logic id, input logic [7:0] data, input logic err);
    check({tag, "_exec_valid"}, 16'(resp_valid), 16'h0000);
    check({tag, "_exec_ready"}, 16'(req_ready), 16'h0000);
    @(negedge clk);
    check({tag, "_valid"}, 16'(resp_valid), 16'h0001);
    check({tag, "_id"},    16'(resp_id),    16'(id));
    check({tag, "_data"},  16'(resp_data),  16'(data));
    check({tag, "_err"},   16'(resp_err),   16'(err));
    check({tag, "_resp_ready"}, 16'(req_ready), 16'h0000);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    check({tag, "_cnt"}, 16'(op_count), 16'(exp_cnt));
    check({tag, "_idle_valid"}, 16'(resp_valid), 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_in1 = 8'h00; req_in2 = 8'h00;
    req_opcode = 4'h0; resp_ready = 1'b0;

    // Reset values.
    do_reset();
    #1;
    check("rst_ready", 16'(req_ready), 16'h0000);
    check("rst_valid", 16'(resp_valid), 16'h0000);
    check("rst_id",    16'(resp_id),    16'h0000);
    check("rst_data",  16'(resp_data),  16'h0000);
    check("rst_err",   16'(resp_err),   16'h0000);
    check("rst_cnt",   16'(op_count),   16'h0000);
    check("rst_in1",   16'(alu_in1),    16'h0000);
    check("rst_in2",   16'(alu_in2),    16'h0000);
    check("rst_op",    16'(alu_opcode), 16'h0000);

    // Single add: 3 + 5.
    @(negedge clk);
    set_req(0, 4'd3, 4'd5, 2'b00);
    grant_step("add_grant", 0);
    check("add_in1", 16'(alu_in1), 16'h0003);
    check("add_in2", 16'(alu_in2), 16'h0005);
    check("add_op",  16'(alu_opcode), 16'h0000);
    expect_resp("add", 1'b0, 8'h08, 1'b0);

    // Contention from reset: req0 15*15, req1 2-3.
    do_reset();
    set_req(0, 4'd15, 4'd15, 2'b10);
    set_req(1, 4'd2, 4'd3, 2'b01);
    grant_step("cont_g0", 0);
    expect_resp("cont_mul", 1'b0, 8'hE1, 1'b0);
    grant_step("cont_g1", 1);
    expect_resp("cont_sub", 1'b1, 8'h0F, 1'b0);
    set_req(0, 4'd1, 4'd1, 2'b00);
    set_req(1, 4'd6, 4'd7, 2'b00);
    grant_step("cont_again_g0", 0);
    expect_resp("cont_again0", 1'b0, 8'h02, 1'b0);
    grant_step("cont_again_g1", 1);
    expect_resp("cont_again1", 1'b1, 8'h0D, 1'b0);

    // Divide, divide by zero, and a zero operand that is not a divide.
    set_req(1, 4'd13, 4'd4, 2'b11);
    grant_step("div_grant", 1);
    expect_resp("div", 1'b1, 8'h03, 1'b0);
    set_req(1, 4'd7, 4'd0, 2'b11);
    grant_step("div0_grant", 1);
    expect_resp("div0", 1'b1, 8'h00, 1'b1);
    set_req(0, 4'd9, 4'd0, 2'b10);
    grant_step("mul0_grant", 0);
    expect_resp("mul0", 1'b0, 8'h00, 1'b0);

    // Backpressure: 10 stalled cycles in RESP with req1 pending.
    set_req(0, 4'd1, 4'd2, 2'b00);
    grant_step("bp_grant", 0);
    set_req(1, 4'd5, 4'd6, 2'b10);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 16'(resp_valid), 16'h0001);
      check("bp_id",    16'(resp_id),    16'h0000);
      check("bp_data",  16'(resp_data),  16'h0003);
      check("bp_ready", 16'(req_ready),  16'h0000);
      check("bp_cnt",   16'(op_count),   16'(exp_cnt));
      @(negedge clk);
    end
    check("bp_last_valid", 16'(resp_valid), 16'h0001);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    check("bp_handoff_cnt", 16'(op_count), 16'(exp_cnt));
    grant_step("bp_next_grant", 1);
    expect_resp("bp_next", 1'b1, 8'h1E, 1'b0);

    // Reset during EXEC with req0 kept pending; it is re-accepted afterwards.
    set_req(0, 4'd4, 4'd1, 2'b01);
    #1;
    check("mid_grant", 16'(req_ready), 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    check("mid_valid", 16'(resp_valid), 16'h0000);
    check("mid_id",    16'(resp_id),    16'h0000);
    check("mid_data",  16'(resp_data),  16'h0000);
    check("mid_err",   16'(resp_err),   16'h0000);
    check("mid_cnt",   16'(op_count),   16'h0000);
    check("mid_in1",   16'(alu_in1),    16'h0000);
    check("mid_in2",   16'(alu_in2),    16'h0000);
    check("mid_op",    16'(alu_opcode), 16'h0000);
    grant_step("mid_regrant", 0);
    expect_resp("mid_redo", 1'b0, 8'h03, 1'b0);

    // Counter wrap: 16 more operations make 17 since reset.
    for (int i = 0; i < 16; i++) begin
      set_req(i % 2, 4'(i), 4'd1, 2'b00);
      grant_step("wrap_grant", i % 2);
      expect_resp("wrap", 1'((i % 2)), 8'(((i + 1) % 16)), 1'b0);
    end
    check("wrap_final", 16'(op_count), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
